cic_out_packer: RTL and testbench



---
 rtl/cic_pack_pkg.sv | 21 ++
 rtl/axis_fifo_2deep.sv | 55 +++++
 rtl/cic_out_packer.sv | 143 ++++++++++++++
 tb/tb_cic_out_packer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pack_pkg.sv
// Shared types and constants for the CIC output packer.
// Word layout, FIFO entry bundle and packer FSM states.
package cic_pack_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  localparam logic [HALF_W-1:0] PAD_HI = 16'h0000;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    ST_EVEN,
    ST_ODD,
    ST_FLUSH_WAIT
  } pack_state_e;

endpackage

// File: rtl/axis_fifo_2deep.sv
// Two-entry AXI-stream skid buffer with occupancy count.
// Head entry always lives in e0_q; the caller never pushes into a full FIFO.
module axis_fifo_2deep
  import cic_pack_pkg::*;
(
  input  logic        clk,
  input  logic        async_reset_n,
  input  logic        push,
  input  fifo_entry_t push_entry,
  input  logic        pop_ready,
  output logic        out_valid,
  output fifo_entry_t out_entry,
  output logic [1:0]  count
);

  fifo_entry_t e0_q;
  fifo_entry_t e1_q;
  logic [1:0]  cnt_q;
  logic        pop;

  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid & pop_ready;
  assign out_entry = out_valid ? e0_q : '0;
  assign count     = cnt_q;

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_q <= push_entry;
          else               e1_q <= push_entry;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          e0_q  <= e1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_q <= push_entry;
          end else begin
            e0_q <= e1_q;
            e1_q <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cic_out_packer.sv
// Packs sign-extended CIC samples two per word and frames them with tlast.
// Flush closes a partial frame; it waits in FLUSH_WAIT while the FIFO is full.
module cic_out_packer
  import cic_pack_pkg::*;
#(
  parameter int DATA_WIDTH = 13,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  async_reset_n,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic                  flush,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [WORD_W-1:0]     m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [LEN_WIDTH-1:0]  frame_count
);

  pack_state_e          state_q, state_d;
  logic                 half_q, half_d;
  logic [HALF_W-1:0]    low_q, low_d;
  logic [LEN_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] frame_count_q;
  logic                 rdy_q;

  logic                 push;
  fifo_entry_t          push_entry;
  fifo_entry_t          head;
  logic                 fifo_valid;
  logic [1:0]           fifo_cnt;
  logic [1:0]           cnt_nxt;

  logic                 acc, pop, space;
  logic                 flush_req, do_flush, pend_d;
  logic                 complete, pad, term, first;
  logic [HALF_W-1:0]    samp_ext;
  logic [LEN_WIDTH-1:0] len_eff;
  logic                 frame_end;

  assign samp_ext = HALF_W'($signed(s_axis_tdata));

  // A new frame takes its length from frame_len; 0 means 1.
  assign len_eff = (word_cnt_q != '0) ? len_q :
                   (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;
  assign frame_end = (word_cnt_q == len_eff - LEN_WIDTH'(1));

  assign acc       = s_axis_tvalid & rdy_q;
  assign pop       = fifo_valid & m_axis_tready;
  assign space     = (fifo_cnt != 2'd2) | pop;
  assign flush_req = flush | (state_q == ST_FLUSH_WAIT);
  assign do_flush  = flush_req & space;

  assign complete = acc & half_q;
  assign pad      = do_flush & (half_q ^ acc);
  assign term     = do_flush & ~half_q & ~acc
                  & (word_cnt_q != '0);
  assign first    = acc & ~half_q & ~do_flush;

  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    half_d     = half_q;
    low_d      = low_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    pend_d     = flush_req & ~space;
    unique case (1'b1)
      complete: begin
        push            = 1'b1;
        push_entry.data = {samp_ext, low_q};
        push_entry.last = frame_end | do_flush;
        half_d          = 1'b0;
        if (word_cnt_q == '0) len_d = len_eff;
        word_cnt_d = push_entry.last ? '0
                   : word_cnt_q + LEN_WIDTH'(1);
      end
      pad: begin
        push            = 1'b1;
        push_entry.data = {PAD_HI, half_q ? low_q : samp_ext};
        push_entry.last = 1'b1;
        half_d          = 1'b0;
        word_cnt_d      = '0;
      end
      term: begin
        push            = 1'b1;
        push_entry.last = 1'b1;
        word_cnt_d      = '0;
      end
      first: begin
        low_d  = samp_ext;
        half_d = 1'b1;
      end
      default: ;
    endcase
    cnt_nxt = fifo_cnt + 2'(push) - 2'(pop);
    state_d = pend_d ? ST_FLUSH_WAIT
            : half_d ? ST_ODD : ST_EVEN;
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q       <= ST_EVEN;
      half_q        <= 1'b0;
      low_q         <= '0;
      word_cnt_q    <= '0;
      len_q         <= '0;
      rdy_q         <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      low_q      <= low_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      rdy_q      <= (cnt_nxt != 2'd2) & ~pend_d;
      if (pop & head.last)
        frame_count_q <= frame_count_q + LEN_WIDTH'(1);
    end
  end

  axis_fifo_2deep u_fifo (
    .clk          (clk),
    .async_reset_n(async_reset_n),
    .push         (push),
    .push_entry   (push_entry),
    .pop_ready    (m_axis_tready),
    .out_valid    (fifo_valid),
    .out_entry    (head),
    .count        (fifo_cnt)
  );

  assign s_axis_tready = rdy_q;
  assign m_axis_tvalid = fifo_valid;
  assign m_axis_tdata  = head.data;
  assign m_axis_tlast  = head.last;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_cic_out_packer.sv
// Bench for cic_out_packer: directed steps plus a random phase,
// scored against a sample-level packing/framing model.
module tb_cic_out_packer;

  localparam int DW = 13;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          async_reset_n;
  logic [LW-1:0] frame_len;
  logic          flush;
  logic          s_axis_tvalid;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tready;
  logic          m_axis_tvalid;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic [LW-1:0] frame_count;

  always #5 clk = ~clk;

  cic_out_packer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .async_reset_n(async_reset_n),
    .frame_len    (frame_len),
    .flush        (flush),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .frame_count  (frame_count)
  );

  int tests = 0;
  int fails = 0;

  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];

  bit          m_have   = 0;
  logic [15:0] m_low    = '0;
  int          m_n      = 0;
  int          m_frames = 0;

  function automatic logic [15:0] ext(input logic [DW-1:0] s);
    return {{(16-DW){s[DW-1]}}, s};
  endfunction

  function automatic int eff_len();
    return (frame_len == 0) ? 1 : int'(frame_len);
  endfunction

  function automatic void m_push(input logic last, input logic [31:0] d);
    exp_q.push_back({last, d});
    if (last) m_frames++;
  endfunction

  // Reference: each accepted sample, then any flush seen in the same cycle.
  initial begin
    bit   fl_used;
    logic lst;
    forever begin
      @(posedge clk or negedge async_reset_n);
      if (!async_reset_n) begin
        m_have = 0; m_n = 0; m_frames = 0;
        exp_q.delete(); got_q.delete();
      end else begin
        fl_used = 0;
        if (s_axis_tvalid && s_axis_tready) begin
          if (!m_have) begin
            m_low  = ext(s_axis_tdata);
            m_have = 1;
          end else begin
            m_n++;
            lst = (m_n == eff_len()) || flush;
            if (lst) m_n = 0;
            m_push(lst, {ext(s_axis_tdata), m_low});
            m_have = 0;
            fl_used = flush;
          end
        end
        if (flush && !fl_used) begin
          if (m_have) begin
            m_push(1'b1, {16'h0000, m_low});
            m_have = 0; m_n = 0;
          end else if (m_n > 0) begin
            m_push(1'b1, 32'h0);
            m_n = 0;
          end
        end
        if (m_axis_tvalid && m_axis_tready)
          got_q.push_back({m_axis_tlast, m_axis_tdata});
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_word(input string tag, input int idx,
                          input logic [32:0] expv);
    logic [32:0] v;
    v = (got_q.size() > idx) ? got_q[idx] : 'x;
    chk(tag, 64'(v), 64'(expv));
  endtask

  task automatic send(input logic [DW-1:0] d);
    int k;
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    flush         = 1'b0;
    k = 0;
    while (!s_axis_tready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("send_ready", 64'(s_axis_tready), 64'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    flush         = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic drain();
    int k;
    m_axis_tready = 1'b1;
    k = 0;
    while (!(got_q.size() == exp_q.size() && !m_axis_tvalid)
           && k < 300) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("drain_idle", 64'(m_axis_tvalid), 64'd0);
  endtask

  task automatic compare_all(input string tag);
    int n;
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    chk({tag, "_frames"}, 64'(frame_count), 64'(m_frames[LW-1:0]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    async_reset_n = 1'b0;
    frame_len     = 16'd2;
    flush         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 64'(s_axis_tready), 64'd0);
    chk("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_m_data",  64'(m_axis_tdata),  64'd0);
    chk("rst_m_last",  64'(m_axis_tlast),  64'd0);
    chk("rst_frames",  64'(frame_count),   64'd0);
    async_reset_n = 1'b1;

    // Two-word frame with sign extension on both halves
    send(13'h0001);
    send(13'h1FFF);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    chk("latency_valid", 64'(m_axis_tvalid), 64'd1);
    send(13'h0FFF);
    send(13'h1000);
    idle();
    drain();
    chk_word("p1_w0", 0, 33'h0_FFFF0001);
    chk_word("p1_w1", 1, 33'h1_F0000FFF);
    chk("p1_frames", 64'(frame_count), 64'd1);
    compare_all("p1");

    // frame_len 0 behaves as 1
    frame_len = 16'd0;
    for (int i = 0; i < 4; i++) send(DW'($urandom));
    idle();
    drain();
    chk_word("len0_last0", 0, {1'b1, exp_q.size() > 0 ? exp_q[0][31:0] : 32'h0});
    chk("len0_frames", 64'(frame_count), 64'd3);
    compare_all("len0");

    // Odd sample count then flush -> pad word
    frame_len = 16'd4;
    send(13'h0123);
    send(13'h0456);
    send(13'h1555);
    pulse_flush();
    drain();
    chk_word("pad_w0", 0, 33'h0_04560123);
    chk_word("pad_w1", 1, 33'h1_0000F555);
    compare_all("pad");

    // Flush after a full word -> terminator; idle flush is a no-op
    send(13'h0007);
    send(13'h1FFE);
    pulse_flush();
    drain();
    chk_word("term_w0", 0, 33'h0_FFFE0007);
    chk_word("term_w1", 1, 33'h1_00000000);
    compare_all("term");
    pulse_flush();
    repeat (5) @(negedge clk);
    chk("noop_valid", 64'(m_axis_tvalid), 64'd0);
    chk("noop_words", 64'(got_q.size()), 64'd0);

    // Downstream stall: FIFO fills to 2 words, flush pends behind it
    m_axis_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'($urandom);
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    chk("stall_s_ready", 64'(s_axis_tready), 64'd0);
    chk("stall_m_valid", 64'(m_axis_tvalid), 64'd1);
    chk("stall_queued", 64'(exp_q.size()), 64'd2);
    pulse_flush();
    repeat (3) @(negedge clk);
    chk("pend_s_ready", 64'(s_axis_tready), 64'd0);
    drain();
    chk_word("stall_flush_w", 2, 33'h1_00000000);
    compare_all("stall");

    // Random traffic, backpressure and flushes
    frame_len = LW'($urandom_range(0, 5));
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      s_axis_tvalid = ($urandom % 4) != 0;
      s_axis_tdata  = DW'($urandom);
      m_axis_tready = ($urandom % 3) != 0;
      flush         = ($urandom % 30) == 0;
    end
    pulse_flush();
    drain();
    compare_all("rand");

    // Reset mid-frame with FIFO full
    frame_len = 16'd3;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'($urandom);
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    chk("pre_rst_valid", 64'(m_axis_tvalid), 64'd1);
    async_reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_ready", 64'(s_axis_tready), 64'd0);
    chk("mid_rst_frames", 64'(frame_count), 64'd0);
    @(negedge clk);
    async_reset_n = 1'b1;
    frame_len     = 16'd2;
    m_axis_tready = 1'b1;
    send(13'h0ABC);
    send(13'h1234);
    send(13'h0001);
    send(13'h0002);
    idle();
    drain();
    chk_word("post_rst_w0", 0, 33'h0_F2340ABC);
    chk_word("post_rst_w1", 1, 33'h1_00020001);
    compare_all("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
